tlc_light_monitor: RTL

Safety monitor on the receive side of the traffic-light controller's lamp bus. It samples the six 2-bit lamp codes (light_M1..light_M4, light_R, light_S) every clock and checks each lamp for invalid codes, illegal colour sequences, short green/yellow dwell, cross-lamp conflicts, and a global stall. The first fault detected is latched with a code and source index for the supervisor. It also counts bus changes for the supervisor.

---
 rtl/tlc_light_monitor.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/tlc_light_monitor.sv
// Lamp-bus safety monitor for the traffic-light controller.
// Samples the six lamp codes every clock and checks for invalid codes,
// cross-lamp conflicts, illegal colour steps, short green/yellow dwell and a
// global stall. The first fault is latched with a code and a source index.
// It also counts the cycles in which the bus changed.
module tlc_light_monitor #(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_STALL  = 100,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] light_M1,
    input  logic [1:0] light_M2,
    input  logic [1:0] light_M3,
    input  logic [1:0] light_M4,
    input  logic [1:0] light_R,
    input  logic [1:0] light_S,
    input  logic       clr_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] fault_src,
    output logic [7:0] change_cnt
);

    localparam int NUM_LAMPS = 6;

    localparam logic [1:0] RED     = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] GREEN   = 2'b10;
    localparam logic [1:0] INVALID = 2'b11;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] GREEN_LIM = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] YELLOW_LIM = CW'(MIN_YELLOW - 1);
    localparam logic [CW-1:0] STALL_LIM = CW'(MAX_STALL - 1);

    localparam logic [2:0] SRC_STALL = 3'd7;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_INVALID  = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_ILLEGAL  = 3'd3,
        FC_SHORT_G  = 3'd4,
        FC_SHORT_Y  = 3'd5,
        FC_STALL    = 3'd6
    } fault_code_e;

    // Lamp codes indexed by source number 0..5.
    logic [1:0] code [NUM_LAMPS];
    assign code[0] = light_M1;
    assign code[1] = light_M2;
    assign code[2] = light_M3;
    assign code[3] = light_M4;
    assign code[4] = light_R;
    assign code[5] = light_S;

    // State registers and their next values.
    logic                 armed_q, armed_d;
    logic [1:0]           prev_q  [NUM_LAMPS];
    logic [1:0]           prev_d  [NUM_LAMPS];
    logic [CW-1:0]        dwell_q [NUM_LAMPS];
    logic [CW-1:0]        dwell_d [NUM_LAMPS];
    logic [NUM_LAMPS-1:0] seen_q, seen_d;
    logic [CW-1:0]        stall_q, stall_d;
    logic [7:0]           change_cnt_q, change_cnt_d;
    logic                 fault_q, fault_d;
    fault_code_e          fault_code_q, fault_code_d;
    logic [2:0]           fault_src_q, fault_src_d;

    // Per-cycle violation vectors, one bit per lamp.
    logic [NUM_LAMPS-1:0] changed, invalid_v, illegal_v, short_g_v, short_y_v, conflict_v;
    logic                 any_change, m_green, stall_v, viol;
    fault_code_e          viol_code;
    logic [2:0]           viol_src;

    // Only the three forward colour steps are legal.
    function automatic logic legal_step(input logic [1:0] from_c, input logic [1:0] to_c);
        return (from_c == RED    && to_c == GREEN)  ||
               (from_c == GREEN  && to_c == YELLOW) ||
               (from_c == YELLOW && to_c == RED);
    endfunction

    // Lowest set index wins when several lamps share a fault code.
    function automatic logic [2:0] first_idx(input logic [NUM_LAMPS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_LAMPS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Violation detection, priority resolution and next-state computation.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // can leave it unassigned and infer a latch.
        changed    = '0;
        invalid_v  = '0;
        illegal_v  = '0;
        short_g_v  = '0;
        short_y_v  = '0;
        conflict_v = '0;
        m_green    = 1'b0;
        viol       = 1'b0;
        viol_code  = FC_NONE;
        viol_src   = 3'd0;

        for (int i = 0; i < NUM_LAMPS; i++) begin
            changed[i]   = code[i] != prev_q[i];
            invalid_v[i] = code[i] == INVALID;
            illegal_v[i] = changed[i] && !legal_step(prev_q[i], code[i]);
            // Dwell checks only trust a lamp once its entry into a colour was observed.
            short_g_v[i] = seen_q[i] && prev_q[i] == GREEN && code[i] != GREEN
                           && dwell_q[i] < GREEN_LIM;
            short_y_v[i] = seen_q[i] && prev_q[i] == YELLOW && code[i] != YELLOW
                           && dwell_q[i] < YELLOW_LIM;
        end
        for (int i = 0; i < 4; i++) begin
            if (code[i] == GREEN) m_green = 1'b1;
        end
        any_change    = |changed;
        conflict_v[4] = code[4] == GREEN && code[2] == GREEN;
        conflict_v[5] = (code[5] == GREEN || code[5] == YELLOW) && m_green;
        stall_v       = !any_change && stall_q >= STALL_LIM;

        if (armed_q) begin
            viol = 1'b1;
            if (|invalid_v) begin
                viol_code = FC_INVALID;  viol_src = first_idx(invalid_v);
            end else if (|conflict_v) begin
                viol_code = FC_CONFLICT; viol_src = first_idx(conflict_v);
            end else if (|illegal_v) begin
                viol_code = FC_ILLEGAL;  viol_src = first_idx(illegal_v);
            end else if (|short_g_v) begin
                viol_code = FC_SHORT_G;  viol_src = first_idx(short_g_v);
            end else if (|short_y_v) begin
                viol_code = FC_SHORT_Y;  viol_src = first_idx(short_y_v);
            end else if (stall_v) begin
                viol_code = FC_STALL;    viol_src = SRC_STALL;
            end else begin
                viol = 1'b0;
            end
        end

        // The first armed-less edge only captures the bus.
        armed_d      = 1'b1;
        prev_d       = code;
        seen_d       = seen_q;
        stall_d      = stall_q;
        change_cnt_d = change_cnt_q;
        for (int i = 0; i < NUM_LAMPS; i++) begin
            dwell_d[i] = dwell_q[i];
        end
        if (armed_q) begin
            for (int i = 0; i < NUM_LAMPS; i++) begin
                if (changed[i]) dwell_d[i] = '0;
                else if (dwell_q[i] != CNT_MAX) dwell_d[i] = dwell_q[i] + 1'b1;
            end
            seen_d = seen_q | changed;
            if (any_change) begin
                stall_d      = '0;
                change_cnt_d = change_cnt_q + 8'd1;
            end else if (stall_q != CNT_MAX) begin
                stall_d = stall_q + 1'b1;
            end
        end

        // A clear on the same edge as a new violation latches the new one.
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        fault_src_d  = fault_src_q;
        if (!fault_q || clr_fault) begin
            if (viol) begin
                fault_d      = 1'b1;
                fault_code_d = viol_code;
                fault_src_d  = viol_src;
            end else if (clr_fault) begin
                fault_d      = 1'b0;
                fault_code_d = FC_NONE;
                fault_src_d  = 3'd0;
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q      <= 1'b0;
            seen_q       <= '0;
            stall_q      <= '0;
            change_cnt_q <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            fault_src_q  <= 3'd0;
            // NOTE: these per-lamp arrays are plain flops, not a RAM, so each
            // entry is reset explicitly; a true memory would not be reset here.
            for (int i = 0; i < NUM_LAMPS; i++) begin
                prev_q[i]  <= RED;
                dwell_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            armed_q      <= armed_d;
            prev_q       <= prev_d;
            dwell_q      <= dwell_d;
            seen_q       <= seen_d;
            stall_q      <= stall_d;
            change_cnt_q <= change_cnt_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fault_src_q  <= fault_src_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign fault_src  = fault_src_q;
    assign change_cnt = change_cnt_q;

endmodule
